// File: rtl/xnor_bist_ctrl.sv
// xnor_bist_ctrl: on-chip sweep of a shared XNOR gate
// drives every {a,b}, checks ~(a^b), logs errors
module xnor_bist_ctrl #(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  input  logic [WIDTH-1:0] dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b
);

  localparam int VW = 2 * WIDTH;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] W_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [VW-1:0]    vec_q, vec_d;
  logic [CW-1:0]    wcnt_q, wcnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fev_q, fev_d;
  logic [WIDTH-1:0] fea_q, fea_d;
  logic [WIDTH-1:0] feb_q, feb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic [WIDTH-1:0] cur_a;
  logic [WIDTH-1:0] cur_b;
  logic [WIDTH-1:0] exp_y;
  logic             miss;
  logic             last;
  logic             err_sat;
  logic             is_idle;
  logic             is_wait;
  logic             is_chk;
  logic             is_done;
  logic             kill;
  logic             go;
  logic             step;
  logic             chk;

  assign cur_a   = vec_q[VW-1:WIDTH];
  assign cur_b   = vec_q[WIDTH-1:0];
  assign exp_y   = ~(cur_a ^ cur_b);
  assign miss    = (dut_y != exp_y);
  assign last    = &vec_q;
  assign err_sat = &err_q;

  assign is_idle = (state_q == S_IDLE);
  assign is_wait = (state_q == S_WAIT);
  assign is_chk  = (state_q == S_CHECK);
  assign is_done = (state_q == S_DONE);

  // abort wins over everything, so the four actions never overlap
  assign kill = abort & ~is_idle;
  assign go   = ~abort & start & (is_idle | is_done);
  assign step = ~abort & is_wait;
  assign chk  = ~abort & is_chk;

  // state register and sweep bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      wcnt_q  <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fea_q   <= '0;
      feb_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fea_q   <= fea_d;
      feb_q   <= feb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // next state, vector stepping and result capture
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fea_d   = fea_q;
    feb_d   = feb_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    unique case (1'b1)
      kill: begin
        state_d = S_IDLE;
        vec_d   = '0;
        wcnt_d  = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
      go: begin
        state_d = S_WAIT;
        vec_d   = '0;
        wcnt_d  = '0;
        err_d   = '0;
        fev_d   = 1'b0;
        fea_d   = '0;
        feb_d   = '0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
      step: begin
        if (wcnt_q == W_LAST) begin
          state_d = S_CHECK;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      chk: begin
        if (miss) begin
          err_d = err_sat ? err_q : err_q + ERR_W'(1);
          if (!fev_q) begin
            fev_d = 1'b1;
            fea_d = cur_a;
            feb_d = cur_b;
          end
        end
        if (last) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          state_d = S_WAIT;
          vec_d   = vec_q + VW'(1);
          wcnt_d  = '0;
        end
      end
      default: begin
      end
    endcase
  end

  assign dut_a           = cur_a;
  assign dut_b           = cur_b;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_a     = fea_q;
  assign first_err_b     = feb_q;

endmodule

// File: tb/tb_xnor_bist_ctrl.sv
// tb_xnor_bist_ctrl: scoreboard bench for the XNOR BIST
// two instances: W1/S2/E8 and W2/S2/E2
module tb_xnor_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start1, abort1;
  logic       start2, abort2;
  logic [1:0] mode1;

  logic       a1, b1, y1;
  logic       busy1, done1, pass1, fev1, fea1, feb1;
  logic [7:0] err1;

  logic [1:0] a2, b2, y2;
  logic       busy2, done2, pass2, fev2;
  logic [1:0] fea2, feb2, err2;

  // 0: good xnor, 1: stuck-at-0, 2: xor
  assign y1 = (mode1 == 2'd0) ? ~(a1 ^ b1) :
              (mode1 == 2'd1) ? 1'b0 : (a1 ^ b1);
  assign y2 = a2 ^ b2;

  xnor_bist_ctrl #(.WIDTH(1), .SETTLE(2), .ERR_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .dut_a(a1), .dut_b(b1), .dut_y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_valid(fev1), .first_err_a(fea1), .first_err_b(feb1)
  );

  xnor_bist_ctrl #(.WIDTH(2), .SETTLE(2), .ERR_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .dut_a(a2), .dut_b(b2), .dut_y(y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_err_valid(fev2), .first_err_a(fea2), .first_err_b(feb2)
  );

  typedef struct {
    int dcyc;
    int err;
    int pass;
    int fev;
    int fa;
    int fb;
  } res_t;

  res_t q1[$];
  res_t q2[$];
  int   tq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic cmp_res(input string tg, input res_t r,
                         input int e, input int p, input int fv,
                         input int fa, input int fb);
    chk({tg, "_done_cyc"}, cyc, r.dcyc);
    chk({tg, "_err"}, e, r.err);
    chk({tg, "_pass"}, p, r.pass);
    chk({tg, "_fev"}, fv, r.fev);
    chk({tg, "_fea"}, fa, r.fa);
    chk({tg, "_feb"}, fb, r.fb);
  endtask

  // monitor: pops expectations when done rises / while tracing
  initial begin
    logic d1q, d2q;
    res_t r;
    int   e;
    d1q = 1'b0;
    d2q = 1'b0;
    forever begin
      @(negedge clk);
      if (done1 && !d1q) begin
        if (q1.size() == 0) begin
          chk("u1_unexpected_done", 1, 0);
        end else begin
          r = q1.pop_front();
          cmp_res("u1", r, int'(err1), int'(pass1), int'(fev1),
                  int'(fea1), int'(feb1));
        end
      end
      if (done2 && !d2q) begin
        if (q2.size() == 0) begin
          chk("u2_unexpected_done", 1, 0);
        end else begin
          r = q2.pop_front();
          cmp_res("u2", r, int'(err2), int'(pass2), int'(fev2),
                  int'(fea2), int'(feb2));
        end
      end
      if (busy1 && tq.size() > 0) begin
        e = tq.pop_front();
        chk("u1_vec_ab", int'({a1, b1}), e);
      end
      d1q = done1;
      d2q = done2;
    end
  end

  task automatic wait_done1();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("u1_done_timeout", 0, 1);
  endtask

  task automatic wait_done2();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done2) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("u2_done_timeout", 0, 1);
  endtask

  task automatic push1(input int dc, input int e, input int p,
                       input int fv, input int fa, input int fb);
    res_t r;
    r.dcyc = dc;
    r.err  = e;
    r.pass = p;
    r.fev  = fv;
    r.fa   = fa;
    r.fb   = fb;
    q1.push_back(r);
  endtask

  task automatic run1(input int e, input int p, input int fv,
                      input int fa, input int fb);
    @(negedge clk);
    push1(cyc + 13, e, p, fv, fa, fb);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_done1();
  endtask

  initial begin
    res_t r;
    int   tv[12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
    rst_n  = 1'b0;
    start1 = 1'b0;
    abort1 = 1'b0;
    start2 = 1'b0;
    abort2 = 1'b0;
    mode1  = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_done", int'(done1), 0);
    chk("rst_pass", int'(pass1), 0);
    chk("rst_err", int'(err1), 0);
    chk("rst_fev", int'(fev1), 0);
    chk("rst_ab", int'({a1, b1}), 0);
    chk("rst_done2", int'(done2), 0);
    rst_n = 1'b1;

    // W=2 xor gate: 16 misses, saturate at 3, done at +48
    @(negedge clk);
    r.dcyc = cyc + 49;
    r.err  = 3;
    r.pass = 0;
    r.fev  = 1;
    r.fa   = 0;
    r.fb   = 0;
    q2.push_back(r);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    wait_done2();

    // clean sweep with operand trace
    mode1 = 2'd0;
    foreach (tv[i]) tq.push_back(tv[i]);
    run1(0, 1, 0, 0, 0);

    // stuck-at-0: misses at (0,0) and (1,1)
    mode1 = 2'd1;
    run1(2, 0, 1, 0, 0);

    // abort sampled at the 6th edge after start
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (5) @(negedge clk);
    abort1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0;
    chk("abort_busy", int'(busy1), 0);
    chk("abort_done", int'(done1), 0);
    chk("abort_pass", int'(pass1), 0);
    chk("abort_ab", int'({a1, b1}), 0);
    chk("abort_err", int'(err1), 1);
    chk("abort_fev", int'(fev1), 1);
    mode1 = 2'd0;
    run1(0, 1, 0, 0, 0);

    // start held high: no restart until done
    mode1 = 2'd1;
    @(negedge clk);
    push1(cyc + 13, 2, 0, 1, 0, 0);
    start1 = 1'b1;
    wait_done1();
    push1(cyc + 13, 2, 0, 1, 0, 0);
    @(negedge clk);
    chk("hold_restart_done", int'(done1), 0);
    chk("hold_restart_busy", int'(busy1), 1);
    chk("hold_restart_err", int'(err1), 0);
    chk("hold_restart_fev", int'(fev1), 0);
    start1 = 1'b0;
    wait_done1();

    // async reset pulse mid-sweep
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy1), 0);
    chk("arst_done", int'(done1), 0);
    chk("arst_err", int'(err1), 0);
    chk("arst_fev", int'(fev1), 0);
    chk("arst_ab", int'({a1, b1}), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("arst_idle_busy", int'(busy1), 0);
    chk("arst_idle_ab", int'({a1, b1}), 0);
    mode1 = 2'd0;
    run1(0, 1, 0, 0, 0);

    repeat (5) @(negedge clk);
    chk("q1_left", q1.size(), 0);
    chk("q2_left", q2.size(), 0);
    chk("trace_left", tq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/xnor_bist_ctrl.md
Name: xnor_bist_ctrl

Overview:
Built-in self-test sequencer for a shared bitwise XNOR gate datapath. On start, it drives every combination of the gate's two operand buses. It waits a programmable settle time, samples the gate output and compares it with the expected XNOR result. It counts mismatches, records the first failing vector and reports pass/fail, replacing the manual stimulus/compare loop with on-chip sequencing.

Parameters:
WIDTH, 1, operand width per input; the sweep covers 2^(2*WIDTH) vectors
SETTLE, 2, cycles each vector is held before the check cycle; legal range >= 1
ERR_W, 8, width of the mismatch counter

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a sweep; sampled in IDLE or DONE only
abort  in  1  synchronous abort of a running sweep
dut_a  out  WIDTH  operand A driven to the gate
dut_b  out  WIDTH  operand B driven to the gate
dut_y  in  WIDTH  gate output under test
busy  out  1  sweep in progress
done  out  1  sweep complete; held until the next start or abort
pass  out  1  valid when done=1; 1 if err_count==0
err_count  out  ERR_W  mismatch count, saturating
first_err_valid  out  1  at least one mismatch recorded
first_err_a  out  WIDTH  dut_a at the first mismatch
first_err_b  out  WIDTH  dut_b at the first mismatch

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset value of all outputs is 0. FSM resets to IDLE.
- The vector counter vec is 2*WIDTH bits. dut_a = vec[2W-1:W] and dut_b = vec[W-1:0], both driven from registers.
- Sweep order: {a,b} = 0,1,2,...,2^(2W)-1. For WIDTH=1 this is (0,0),(0,1),(1,0),(1,1).
- Expected output is ~(dut_a ^ dut_b), computed bitwise. A mismatch is any bit differing.
- FSM states: IDLE, WAIT, CHECK, DONE.
  - IDLE/DONE with start=1 at edge: vec<=0, wait_cnt<=0, err_count<=0, first_err_* <=0, done<=0, busy<=1, go to WAIT.
  - WAIT: wait_cnt increments each edge. When wait_cnt==SETTLE-1, go to CHECK.
  - CHECK, one cycle: compare dut_y with the expected value at this edge.
    - On mismatch: err_count increments, saturating at 2^ERR_W-1.
    - On mismatch with first_err_valid=0: capture dut_a/dut_b and set first_err_valid.
    - If vec is the last vector: busy<=0, done<=1, go to DONE.
    - Otherwise: vec<=vec+1, wait_cnt<=0, go to WAIT.
- Each vector occupies SETTLE+1 cycles. done rises 2^(2W)*(SETTLE+1) edges after the start edge. For WIDTH=1, SETTLE=2 this is 12.
- pass = done & (err_count==0), registered together with done.
- start while busy is ignored.
- abort, in any state other than IDLE, returns the FSM to IDLE at the next edge:
  - busy=0, done=0, pass=0, vec=0.
  - err_count and first_err_* retain their values for debug.
  - abort has priority over start in the same cycle.
- rst_n low mid-sweep: immediate return to IDLE with all outputs 0. No sweep resumes after release until a new start.
- vec does not wrap. The last-vector check stops the sweep before increment.

Test Plan:
- Correct XNOR model, WIDTH=1, SETTLE=2, 1-cycle start pulse:
  - busy=1 next cycle; dut_a/dut_b step (0,0),(0,1),(1,0),(1,1), each held 3 cycles.
  - done=1 at start+12; err_count=0, pass=1, first_err_valid=0.
- Stuck-at-0 gate model: err_count=2, first_err_a=0, first_err_b=0, pass=0, done=1.
- WIDTH=2, ERR_W=2, XOR model instead of XNOR: 16 mismatches, err_count saturates at 3, first error at (0,0), done at start+48.
- abort asserted during the 6th cycle of a sweep:
  - next cycle busy=0, done=0, dut_a=dut_b=0, err_count unchanged.
  - A new start then completes a clean sweep with pass=1.
- start held high throughout a sweep: no restart while busy. After done=1, the next cycle with start=1 restarts and clears err_count and done.
- rst_n pulsed low mid-sweep for 1 ns (asynchronous, between edges): all outputs 0 immediately; FSM idle until the next start.
